mult_seq: RTL

Sequencer that runs a 32x32 unsigned shift-add multiply on operands held in the 16x32 register bank and writes the 64-bit product back into two consecutive bank registers. It sits between the instruction/control front end and the register bank, and owns the bank's load, destination, source-select and write-data ports for the duration of an operation. One operation is in flight at a time, with a start/busy/done handshake.

---
 rtl/mult_pkg.sv | 25 ++
 rtl/mult_dp.sv | 64 ++++++
 rtl/mult_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM states, iteration
// count, reserved bank addresses and the destination legality check.
package mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_RUN   = 3'd2,
    S_WRLO  = 3'd3,
    S_WRHI  = 3'd4,
    S_DONE  = 3'd5
  } mstate_t;

  localparam int ITER = 32;

  localparam logic [3:0] REG_ZERO   = 4'h0;
  localparam logic [3:0] REG_COUT   = 4'hF;
  localparam logic [3:0] REG_LASTWR = 4'hD;

  // dst and dst+1 must both be writable bank registers
  function automatic logic dst_ok(input logic [3:0] dst);
    return (dst != REG_ZERO) && (dst != REG_COUT) && (dst <= REG_LASTWR);
  endfunction

endpackage

// File: rtl/mult_dp.sv
// Shift-add datapath: multiplicand M, accumulator A and multiplier/low-product Q.
// The adder carry is folded directly into the right shift each step.
module mult_dp (
  input  logic        ck,
  input  logic        rb,
  input  logic        clr_i,
  input  logic        cap_i,
  input  logic        step_i,
  input  logic [31:0] m_in_i,
  input  logic [31:0] q_in_i,
  output logic [31:0] a_o,
  output logic [31:0] q_o,
  output logic [31:0] q_nxt_o
);

  logic [31:0] m_q, a_q, q_q;
  logic [31:0] m_d, a_d, q_d;
  logic [32:0] sum_s;

  always_comb begin
    if (q_q[0]) begin
      sum_s = {1'b0, a_q} + {1'b0, m_q};
    end else begin
      sum_s = {1'b0, a_q};
    end
  end

  always_comb begin
    m_d = m_q;
    a_d = a_q;
    q_d = q_q;
    if (clr_i) begin
      m_d = 32'd0;
      a_d = 32'd0;
      q_d = 32'd0;
    end else if (cap_i) begin
      m_d = m_in_i;
      a_d = 32'd0;
      q_d = q_in_i;
    end else if (step_i) begin
      a_d = sum_s[32:1];
      q_d = {sum_s[0], q_q[31:1]};
    end else begin
      m_d = m_q;
    end
  end

  always_ff @(posedge ck or negedge rb) begin
    if (!rb) begin
      m_q <= 32'd0;
      a_q <= 32'd0;
      q_q <= 32'd0;
    end else begin
      m_q <= m_d;
      a_q <= a_d;
      q_q <= q_d;
    end
  end

  assign a_o     = a_q;
  assign q_o     = q_q;
  assign q_nxt_o = {sum_s[0], q_q[31:1]};

endmodule

// File: rtl/mult_seq.sv
// Multiply sequencer: fetches two bank operands, runs 32 shift-add steps and
// writes the 64-bit product to dst/dst+1 through registered bank port drives.
module mult_seq
  import mult_pkg::*;
(
  input  logic        ck,
  input  logic        rb,
  input  logic        start,
  input  logic [3:0]  srca,
  input  logic [3:0]  srcb,
  input  logic [3:0]  dst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        bk_load,
  output logic [3:0]  bk_dest,
  output logic [3:0]  bk_srcs,
  output logic [3:0]  bk_srct,
  output logic [31:0] bk_inp,
  input  logic [31:0] bk_outs,
  input  logic [31:0] bk_outt,
  input  logic        bk_tzro
);

  localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

  mstate_t     state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  dst_q, dst_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d, load_q, load_d;
  logic [3:0]  dest_q, dest_d, srcs_q, srcs_d, srct_q, srct_d;
  logic [31:0] inp_q, inp_d;
  logic        dp_clr_s, dp_cap_s, dp_step_s;
  logic [31:0] a_s, q_s, q_nxt_s;

  mult_dp u_dp (
    .ck      (ck),
    .rb      (rb),
    .clr_i   (dp_clr_s),
    .cap_i   (dp_cap_s),
    .step_i  (dp_step_s),
    .m_in_i  (bk_outs),
    .q_in_i  (bk_outt),
    .a_o     (a_s),
    .q_o     (q_s),
    .q_nxt_o (q_nxt_s)
  );

  // Output registers are loaded one cycle ahead so each state sees its drive.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dst_d     = dst_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    load_d    = 1'b0;
    dest_d    = dest_q;
    srcs_d    = srcs_q;
    srct_d    = srct_q;
    inp_d     = 32'd0;
    dp_clr_s  = 1'b0;
    dp_cap_s  = 1'b0;
    dp_step_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && dst_ok(dst)) begin
          srcs_d  = srca;
          srct_d  = srcb;
          dst_d   = dst;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end else if (start) begin
          err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        cnt_d = 5'd0;
        if (bk_tzro || (bk_outs == 32'd0)) begin
          dp_clr_s = 1'b1;
          load_d   = 1'b1;
          dest_d   = dst_q;
          state_d  = S_WRLO;
        end else begin
          dp_cap_s = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        dp_step_s = 1'b1;
        cnt_d     = cnt_q + 5'd1;
        // Low word is taken from the step completing on this same edge
        if (cnt_q == CNT_LAST) begin
          load_d  = 1'b1;
          dest_d  = dst_q;
          inp_d   = q_nxt_s;
          state_d = S_WRLO;
        end else begin
          state_d = S_RUN;
        end
      end
      S_WRLO: begin
        load_d  = 1'b1;
        dest_d  = dst_q + 4'd1;
        inp_d   = a_s;
        state_d = S_WRHI;
      end
      S_WRHI: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        dp_clr_s = 1'b1;
        cnt_d    = 5'd0;
        state_d  = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rb) begin
    if (!rb) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      dst_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      dest_q  <= 4'd0;
      srcs_q  <= 4'd0;
      srct_q  <= 4'd0;
      inp_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      load_q  <= load_d;
      dest_q  <= dest_d;
      srcs_q  <= srcs_d;
      srct_q  <= srct_d;
      inp_q   <= inp_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign bk_load = load_q;
  assign bk_dest = dest_q;
  assign bk_srcs = srcs_q;
  assign bk_srct = srct_q;
  assign bk_inp  = inp_q;

  logic unused_s;
  assign unused_s = ^q_s;

endmodule
